// File: rtl/regfile_scoreboard_arbiter.sv
// regfile_scoreboard_arbiter: round-robin ALU/LSU writeback arbiter driving the register file write port,
// plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards until the producer commits.
module regfile_scoreboard_arbiter #(
    parameter int WORD = 32,
    parameter int REGISTER_NUMBER = 32,
    localparam int RW = $clog2(REGISTER_NUMBER)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  logic [RW-1:0]              issue_rs1,
    input  logic [RW-1:0]              issue_rs2,
    input  logic [RW-1:0]              issue_rd,
    input  logic                       issue_rd_we,
    output logic                       issue_ready,
    input  logic                       alu_wb_valid,
    input  logic [RW-1:0]              alu_wb_rd,
    input  logic [WORD-1:0]            alu_wb_data,
    output logic                       alu_wb_ready,
    input  logic                       lsu_wb_valid,
    input  logic [RW-1:0]              lsu_wb_rd,
    input  logic [WORD-1:0]            lsu_wb_data,
    output logic                       lsu_wb_ready,
    output logic                       rf_write_enable,
    output logic [RW-1:0]              rf_write_select,
    output logic [WORD-1:0]            rf_data_in,
    output logic [REGISTER_NUMBER-1:0] busy_vec,
    output logic                       wb_error
);
    localparam logic [REGISTER_NUMBER-1:0] ONE = 1;
    logic [REGISTER_NUMBER-1:0] busy;
    logic [REGISTER_NUMBER-1:0] set_vec;
    logic [REGISTER_NUMBER-1:0] clr_vec;
    logic                       last_lsu;
    logic                       alu_grant;
    logic                       lsu_grant;
    logic                       fire;
    logic [RW-1:0]              grant_rd;
    logic [WORD-1:0]            grant_data;
    assign alu_wb_ready = alu_grant;
    assign lsu_wb_ready = lsu_grant;
    assign busy_vec     = busy;
    always_comb begin
        alu_grant   = alu_wb_valid && (!lsu_wb_valid || last_lsu);
        lsu_grant   = lsu_wb_valid && !alu_grant;
        grant_rd    = alu_grant ? alu_wb_rd : lsu_wb_rd;
        grant_data  = alu_grant ? alu_wb_data : lsu_wb_data;
        issue_ready = !busy[issue_rs1] && !busy[issue_rs2] && !(issue_rd_we && busy[issue_rd]);
        fire        = issue_valid && issue_ready && issue_rd_we && issue_rd != '0;
        set_vec     = fire ? ONE << issue_rd : '0;
        clr_vec     = rf_write_enable ? ONE << rf_write_select : '0;
    end
    // set is applied after clear so a new producer of the committing register stays pending
    always_ff @(posedge clk) begin
        if (reset) begin
            busy            <= '0;
            rf_write_enable <= 1'b0;
            rf_write_select <= '0;
            rf_data_in      <= '0;
            wb_error        <= 1'b0;
            last_lsu        <= 1'b1;
        end else begin
            busy            <= ((busy & ~clr_vec) | set_vec) & ~ONE;
            rf_write_enable <= (alu_grant || lsu_grant) && grant_rd != '0;
            if (alu_grant || lsu_grant) begin
                rf_write_select <= grant_rd;
                rf_data_in      <= grant_data;
                last_lsu        <= lsu_grant;
            end
            if (rf_write_enable && !busy[rf_write_select])
                wb_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard_arbiter.sv
// tb_regfile_scoreboard_arbiter: directed per-cycle vector table plus hand-written contention and stall sequences.
module tb_regfile_scoreboard_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_rd_we, issue_ready;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  alu_wb_rd, lsu_wb_rd, rf_write_select;
    logic [31:0] alu_wb_data, lsu_wb_data, rf_data_in, busy_vec;
    logic        rf_write_enable, wb_error;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_arbiter #(.WORD(32), .REGISTER_NUMBER(32)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .lsu_wb_ready(lsu_wb_ready),
        .rf_write_enable(rf_write_enable), .rf_write_select(rf_write_select),
        .rf_data_in(rf_data_in), .busy_vec(busy_vec), .wb_error(wb_error)
    );

    typedef struct {
        logic        rst, iv, rdwe, av, lv, dc;
        logic [4:0]  rs1, rs2, rd, ard, lrd;
        logic [31:0] ad, ld;
        logic [73:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [73:0] pk(logic ir, logic ar, logic lr, logic we, logic [4:0] sel,
                                       logic [31:0] data, logic [31:0] busy, logic err);
        return {ir, ar, lr, we, sel, data, busy, err};
    endfunction

    function automatic void add(logic rst, logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic rdwe, logic av, logic [4:0] ard, logic [31:0] ad, logic lv,
                                logic [4:0] lrd, logic [31:0] ld, logic ir, logic ar, logic lr,
                                logic we, logic [4:0] sel, logic [31:0] data, logic [31:0] busy,
                                logic err, logic dc);
        vec_t v;
        v.rst = rst; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rdwe = rdwe;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld; v.dc = dc;
        v.exp = pk(ir, ar, lr, we, sel, data, busy, err);
        vq.push_back(v);
    endfunction

    task automatic drive(vec_t v);
        reset = v.rst; issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs2 = v.rs2;
        issue_rd = v.rd; issue_rd_we = v.rdwe;
        alu_wb_valid = v.av; alu_wb_rd = v.ard; alu_wb_data = v.ad;
        lsu_wb_valid = v.lv; lsu_wb_rd = v.lrd; lsu_wb_data = v.ld;
    endtask

    task automatic check(string nm, logic [73:0] got, logic [73:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    initial begin
        vec_t        idle;
        logic [73:0] got, m;
        int          w;
        idle = '{rst: 1'b1, iv: 1'b0, rdwe: 1'b0, av: 1'b0, lv: 1'b0, dc: 1'b0,
                 rs1: 5'd0, rs2: 5'd0, rd: 5'd0, ard: 5'd0, lrd: 5'd0, ad: 32'h0, ld: 32'h0, exp: '0};
        drive(idle);
        //   rst iv rs1 rs2 rd we  av ard ad            lv lrd ld          ir ar lr we sel data          busy        err dc
        add(1, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 0, 32'h0,        32'h0,      0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 0, 32'h0,        32'h0,      0, 0);
        add(0, 1, 1, 2, 5, 1,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 0, 32'h0,        32'h0,      0, 0);
        add(0, 1, 5, 0, 6, 1,  1, 5, 32'hDEADBEEF, 0, 0, 32'h0,     0, 1, 0, 0, 0, 32'h0,        32'h20,     0, 0);
        add(0, 1, 5, 0, 6, 1,  0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h20,     0, 0);
        add(0, 1, 5, 0, 6, 1,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 5, 32'hDEADBEEF, 32'h0,      0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        1, 0, 32'h1234,  1, 0, 1, 0, 5, 32'hDEADBEEF, 32'h40,     0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 0, 32'h0,        32'h40,     0, 1);
        add(1, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 0, 32'h0,        32'h40,     0, 1);
        add(0, 0, 0, 0, 0, 0,  1, 3, 32'hA3,       1, 4, 32'hB4,    1, 1, 0, 0, 0, 32'h0,        32'h0,      0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 3, 32'hA3,       1, 4, 32'hB4,    1, 0, 1, 1, 3, 32'hA3,       32'h0,      0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 3, 32'hA3,       1, 4, 32'hB4,    1, 1, 0, 1, 4, 32'hB4,       32'h0,      1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 3, 32'hA3,       1, 4, 32'hB4,    1, 0, 1, 1, 3, 32'hA3,       32'h0,      1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 1, 4, 32'hB4,       32'h0,      1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 4, 32'hB4,       32'h0,      1, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 4, 32'hB4,       32'h0,      1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 9, 32'h99,       0, 0, 32'h0,     1, 1, 0, 0, 0, 32'h0,        32'h0,      0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 1, 9, 32'h99,       32'h0,      0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 9, 32'h99,       32'h0,      1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 9, 32'h99,       32'h0,      1, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 9, 32'h99,       32'h0,      1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 0, 32'h0,        32'h0,      0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 7, 32'h77,       0, 0, 32'h0,     1, 1, 0, 0, 0, 32'h0,        32'h0,      0, 0);
        add(0, 1, 1, 2, 7, 1,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 1, 7, 32'h77,       32'h0,      0, 0);
        add(0, 1, 0, 7, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 0, 0, 7, 32'h77,       32'h80,     1, 0);
        add(0, 1, 0, 0, 7, 1,  0, 0, 32'h0,        0, 0, 32'h0,     0, 0, 0, 0, 7, 32'h77,       32'h80,     1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        1, 7, 32'h55,    1, 0, 1, 0, 7, 32'h77,       32'h80,     1, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 1, 7, 32'h55,       32'h80,     1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,     1, 0, 0, 0, 0, 32'h0,        32'h0,      0, 0);
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            got = pk(issue_ready, alu_wb_ready, lsu_wb_ready, rf_write_enable, rf_write_select,
                     rf_data_in, busy_vec, wb_error);
            m = '1;
            if (vq[i].dc) m[69:33] = '0;
            check($sformatf("vec%0d", i), got & m, vq[i].exp & m);
        end
        // sustained contention after reset: grants alternate, selects follow one cycle later
        @(negedge clk);
        drive(idle);
        @(negedge clk);
        reset = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = 32'hA0A0;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd11; lsu_wb_data = 32'hB0B0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("rr_grant%0d", i), {72'h0, alu_wb_ready, lsu_wb_ready},
                  {72'h0, i % 2 == 0, i % 2 == 1});
            if (i > 0)
                check($sformatf("rr_sel%0d", i), {68'h0, rf_write_enable, rf_write_select},
                      {68'h0, 1'b1, (i % 2 == 1) ? 5'd10 : 5'd11});
        end
        // RAW stall release: ready returns exactly two cycles after the grant cycle
        @(negedge clk);
        drive(idle);
        reset = 1'b0;
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd12; issue_rd_we = 1'b1;
        @(negedge clk);
        issue_rs1 = 5'd12; issue_rd = 5'd0; issue_rd_we = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd12; alu_wb_data = 32'hC;
        #1;
        check("stall_grant", {72'h0, issue_ready, alu_wb_ready}, {72'h0, 1'b0, 1'b1});
        @(negedge clk);
        alu_wb_valid = 1'b0;
        #1;
        w = 1;
        while (!issue_ready && w < 6) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("stall_release", {73'h0, issue_ready}, {73'h0, 1'b1});
        check("stall_cycles", 74'(w), 74'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
